mat_result_store: RTL and testbench
===================================

Name: mat_result_store

Overview:
- Write-back engine for the matrix unit: the store-direction counterpart of the matrix load path, which streams matrix A/B from data memory into the matrix unit.
- On a store request from the EX/MEM stage, it waits for the matrix unit's `done`, snapshots the 3x3 result R_11..R_33, then writes the nine words sequentially into data memory from a base address.
- Sits beside Data_Memory; its write port is muxed into the memory write path while busy.
- Asserts a stall to hold the pipeline until the store completes.

Parameters:
- DATA_W, 32, width of each result element and of memory write data
- ADDR_W, 32, memory address width
- N, 3, matrix dimension; the block handles N*N elements
- ADDR_STRIDE, 4, byte increment between consecutive element addresses
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT_DONE (used only with MATSTORE_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- store_req  in  1  single-cycle request from EX/MEM (matrix store opcode)
- base_addr  in  ADDR_W  destination base address, sampled with store_req
- mat_done  in  1  matrix unit `done`; results valid while high
- r_vec  in  N*N*DATA_W  packed results; element (i,j), 0-based, at bits [DATA_W*(N*i+j) +: DATA_W], row-major
- mem_ready  in  1  data memory accepts the current write this cycle
- mem_we  out  1  write request to data memory
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- busy  out  1  high in any state other than IDLE
- stall  out  1  pipeline hold (PC/IF-ID write disable); equals busy
- store_done  out  1  one-cycle pulse when the last element has been accepted
- err  out  1  one-cycle pulse on timeout abort (tied 0 without the macro)

Behaviour:
- Reset: state=IDLE, idx=0; all outputs 0. The capture buffer is not cleared.
- Reset mid-operation aborts at once. No further mem_we is issued, and no store_done or err is pulsed.
- States: IDLE, WAIT_DONE, WRITE, FINISH.
- IDLE:
  - On store_req=1, latch base_addr, set idx=0, and go to WAIT_DONE.
  - store_req with mat_done=1 in the same cycle still goes through WAIT_DONE; capture happens on the next edge.
- WAIT_DONE:
  - When mat_done=1, capture all N*N elements of r_vec into the buffer in one cycle, then go to WRITE.
  - Results are frozen from this point; later changes on r_vec are ignored.
- WRITE:
  - mem_we=1, mem_addr = base + idx*ADDR_STRIDE (mod 2^ADDR_W, wrap allowed), mem_wdata = buf[idx].
  - mem_addr and mem_wdata are registered and must be stable while mem_we=1 and mem_ready=0.
  - On mem_ready=1: if idx = N*N-1, go to FINISH; otherwise idx+1 and present the next word on the next cycle.
  - Throughput with mem_ready tied high: one word per cycle.
- FINISH: store_done=1 for one cycle, mem_we=0, then return to IDLE.
- store_req while busy is ignored: no queueing and no restart.
- stall is combinationally equal to busy, so it rises the cycle after store_req.
- Latency with mem_ready=1 and mat_done already high: store_req at cycle 0; capture at edge 1; first write presented in cycle 2; last write in cycle 10; store_done in cycle 11; busy low in cycle 12.
- mem_we is never asserted outside WRITE.

Optional Feature:
- Macro: MATSTORE_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_DONE.
  - If mat_done is still 0 after TIMEOUT_CYCLES cycles, pulse err for one cycle, issue no writes, and return to IDLE (store_done stays 0).
  - The counter clears on entry to WAIT_DONE.
- Undefined:
  - No counter exists and err is tied 0.
  - WAIT_DONE waits indefinitely for mat_done.

Test Plan:
- Basic store:
  - Stimulus: r_vec elements = 1..9 row-major, mat_done=1, mem_ready=1, store_req with base_addr=0x100.
  - Required: writes (0x100,1), (0x104,2) … (0x120,9) on consecutive cycles; store_done in the cycle after the last write; stall high throughout.
- Backpressure:
  - Stimulus: mem_ready low for 3 cycles on idx 4.
  - Required: mem_addr holds 0x110 and mem_wdata holds 5 during the stall; sequence resumes; exactly 9 accepted writes total.
- Late done and snapshot:
  - Stimulus: mat_done rises 20 cycles after store_req; r_vec changes to all 0xFFFFFFFF one cycle after capture.
  - Required: no mem_we before capture; the written values are the pre-change results.
- Ignored request and wrap:
  - Stimulus: second store_req mid-write; then base_addr=0xFFFFFFFC.
  - Required: the second request has no effect; the wrap store addresses are 0xFFFFFFFC, 0x0, 0x4 … 0x1C.
- Reset mid-store:
  - Stimulus: reset asserted during idx=3.
  - Required: next cycle mem_we=0, busy=0, stall=0, store_done=0; a fresh store afterwards completes normally.
- Timeout (MATSTORE_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: mat_done never asserted.
  - Required: err pulses once, with no writes and no store_done; busy drops the following cycle.

Source files
------------

// File: rtl/mat_result_store.sv
// Matrix result write-back engine: snapshots the N*N result vector on mat_done and
// streams it to data memory word by word. Define MATSTORE_TIMEOUT_EN for the WAIT_DONE watchdog.
module mat_result_store #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned N              = 3,
    parameter int unsigned ADDR_STRIDE    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  store_req,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  mat_done,
    input  logic [N*N*DATA_W-1:0] r_vec,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  busy,
    output logic                  stall,
    output logic                  store_done,
    output logic                  err
);

    localparam int unsigned NE = N * N;
    localparam int unsigned IW = (NE > 1) ? $clog2(NE) : 1;

    if (N < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("mat_result_store: N and TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        WRITE,
        FINISH
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_next;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   res_buf [NE];
    logic                last_word;
    logic                timeout_hit;

    assign idx_next  = idx + IW'(1);
    assign last_word = (idx == IW'(NE - 1));

`ifdef MATSTORE_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    assign timeout_hit = (state == WAIT_DONE) && !mat_done &&
                         (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (store_req) state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (mat_done)         state_next = WRITE;
                else if (timeout_hit) state_next = IDLE;
            end
            WRITE:     if (mem_ready && last_word) state_next = FINISH;
            FINISH:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    assign mem_we     = (state == WRITE);
    assign busy       = (state != IDLE);
    assign stall      = busy;
    assign store_done = (state == FINISH);
    assign err        = timeout_hit;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    // Capture buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && state == WAIT_DONE && mat_done) begin
            for (int unsigned i = 0; i < NE; i++) begin
                res_buf[i] <= r_vec[DATA_W*i +: DATA_W];
            end
        end
    end

    // First word comes straight from r_vec since the buffer is loaded on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (store_req) begin
                        base_q <= base_addr;
                        idx    <= '0;
                    end
                end
                WAIT_DONE: begin
                    if (mat_done) begin
                        idx     <= '0;
                        addr_q  <= base_q;
                        wdata_q <= r_vec[DATA_W-1:0];
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        if (last_word) begin
                            addr_q  <= '0;
                            wdata_q <= '0;
                        end else begin
                            idx     <= idx_next;
                            addr_q  <= addr_q + ADDR_W'(ADDR_STRIDE);
                            wdata_q <= res_buf[idx_next];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_result_store.sv
// Self-checking bench for mat_result_store: randomized result vectors checked against
// an address/data model computed directly from base + k*stride and the captured elements.
module tb_mat_result_store;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NN  = 3;
    localparam int NE  = NN * NN;
    localparam int STR = 4;
`ifdef MATSTORE_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              store_req;
    logic [AW-1:0]     base_addr;
    logic              mat_done;
    logic [NE*DW-1:0]  r_vec;
    logic              mem_ready;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              busy;
    logic              stall;
    logic              store_done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] wq_addr[$];
    logic [DW-1:0] wq_data[$];
    int done_cnt  = 0;
    int err_cnt   = 0;
    int err_total = 0;
    int stall_bad = 0;

    mat_result_store #(
        .DATA_W(DW), .ADDR_W(AW), .N(NN), .ADDR_STRIDE(STR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .store_req(store_req), .base_addr(base_addr),
        .mat_done(mat_done), .r_vec(r_vec), .mem_ready(mem_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .stall(stall), .store_done(store_done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we && mem_ready) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
        end
        if (store_done) done_cnt++;
        if (err) begin err_cnt++; err_total++; end
        if (stall !== busy) stall_bad++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log;
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic rand_vec(output logic [NE*DW-1:0] v);
        for (int k = 0; k < NE; k++) v[DW*k +: DW] = $urandom;
    endtask

    task automatic start_store(input logic [AW-1:0] b, input logic [NE*DW-1:0] v, input logic done);
        base_addr = b;
        r_vec     = v;
        mat_done  = done;
        store_req = 1'b1;
        tick();
        store_req = 1'b0;
    endtask

    task automatic wait_store_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (store_done) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; store_req = 1'b0; mat_done = 1'b0; mem_ready = 1'b1;
        base_addr = '0; r_vec = '0;
        tick(); tick();
        n_checks++; if ({mem_we, busy, stall, store_done, err} !== 5'b0) begin n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {mem_we, busy, stall, store_done, err}); end
        n_checks++; if (mem_addr !== '0) begin n_fail++;
            $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        n_checks++; if (mem_wdata !== '0) begin n_fail++;
            $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        logic [NE*DW-1:0] v;
        logic [AW-1:0]    b;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                b = 32'h100;
                for (int k = 0; k < NE; k++) v[DW*k +: DW] = DW'(k + 1);
            end else begin
                b = $urandom;
                rand_vec(v);
            end
            clear_log();
            mem_ready = 1'b1;
            base_addr = b; r_vec = v; mat_done = 1'b1; store_req = 1'b1;
            n_checks++; if (busy !== 1'b0) begin n_fail++;
                $display("FAIL basic_idle_busy: got %b expected 0", busy); end
            tick();
            store_req = 1'b0;
            n_checks++; if ({busy, stall, mem_we} !== 3'b110) begin n_fail++;
                $display("FAIL basic_cycle1: busy/stall/we got %b expected 110", {busy, stall, mem_we}); end
            tick();
            for (int k = 0; k < NE; k++) begin
                n_checks++;
                if (mem_we !== 1'b1 || mem_addr !== b + AW'(k * STR) || mem_wdata !== v[DW*k +: DW]) begin
                    n_fail++;
                    $display("FAIL basic_write[%0d]: got we=%b %h/%h expected we=1 %h/%h", k,
                             mem_we, mem_addr, mem_wdata, b + AW'(k * STR), v[DW*k +: DW]);
                end
                tick();
            end
            n_checks++; if ({store_done, mem_we, busy} !== 3'b101) begin n_fail++;
                $display("FAIL basic_finish: done/we/busy got %b expected 101", {store_done, mem_we, busy}); end
            mat_done = 1'b0;
            tick();
            n_checks++; if ({store_done, busy, stall} !== 3'b000) begin n_fail++;
                $display("FAIL basic_idle_after: done/busy/stall got %b expected 000", {store_done, busy, stall}); end
            n_checks++; if (wq_addr.size() !== NE || done_cnt !== 1) begin n_fail++;
                $display("FAIL basic_counts: writes %0d dones %0d expected %0d 1", wq_addr.size(), done_cnt, NE); end
        end
    endtask

    task automatic test_backpressure;
        logic [NE*DW-1:0] v;
        logic [AW-1:0]    b;
        int acc, hold;
        bit ok, ready;
        for (int pass = 0; pass < 2; pass++) begin
            clear_log();
            rand_vec(v);
            b = (pass == 0) ? 32'h100 : $urandom;
            mem_ready = 1'b1;
            start_store(b, v, 1'b1);
            acc = 0; hold = 0; ok = 1'b0;
            for (int c = 0; c < 100; c++) begin
                if (store_done) begin ok = 1'b1; break; end
                if (pass == 0) ready = !(acc == 4 && hold < 3);
                else           ready = ($urandom_range(0, 3) != 0);
                if (mem_we) begin
                    n_checks++;
                    if (mem_addr !== b + AW'(acc * STR) || mem_wdata !== v[DW*acc +: DW]) begin
                        n_fail++;
                        $display("FAIL bp_word[%0d]: got %h/%h expected %h/%h", acc,
                                 mem_addr, mem_wdata, b + AW'(acc * STR), v[DW*acc +: DW]);
                    end
                    if (ready) acc++; else hold++;
                end
                mem_ready = ready;
                tick();
            end
            n_checks++; if (!ok || acc !== NE) begin n_fail++;
                $display("FAIL bp_complete: done_seen=%b accepted %0d expected 1 %0d", ok, acc, NE); end
            if (pass == 0) begin
                n_checks++; if (hold !== 3) begin n_fail++;
                    $display("FAIL bp_hold: got %0d expected 3", hold); end
            end
            mem_ready = 1'b1; mat_done = 1'b0;
            tick(); tick();
            n_checks++; if (wq_addr.size() !== NE || done_cnt !== 1 || busy !== 1'b0) begin n_fail++;
                $display("FAIL bp_counts: writes %0d dones %0d busy %b expected %0d 1 0",
                         wq_addr.size(), done_cnt, busy, NE); end
        end
    endtask

    task automatic test_late_done_snapshot;
        logic [NE*DW-1:0] v;
        logic [AW-1:0]    b;
        int early_we;
        bit ok;
        clear_log();
        rand_vec(v);
        b = $urandom;
        mem_ready = 1'b1;
        start_store(b, v, 1'b0);
        early_we = 0;
        for (int c = 1; c < 20; c++) begin
            if (mem_we) early_we++;
            tick();
        end
        if (mem_we) early_we++;
        mat_done = 1'b1;
        tick();
        r_vec = '1;
        mat_done = 1'b0;
        n_checks++; if (early_we !== 0 || busy !== 1'b1) begin n_fail++;
            $display("FAIL late_early_we: early writes %0d busy %b expected 0 1", early_we, busy); end
        wait_store_done(40, ok);
        tick();
        n_checks++; if (!ok || wq_addr.size() !== NE) begin n_fail++;
            $display("FAIL late_count: done=%b writes %0d expected 1 %0d", ok, wq_addr.size(), NE); end
        for (int k = 0; k < NE; k++) begin
            n_checks++;
            if (wq_addr[k] !== b + AW'(k * STR) || wq_data[k] !== v[DW*k +: DW]) begin
                n_fail++;
                $display("FAIL late_snapshot[%0d]: got %h/%h expected %h/%h", k,
                         wq_addr[k], wq_data[k], b + AW'(k * STR), v[DW*k +: DW]);
            end
        end
    endtask

    task automatic test_ignored_and_wrap;
        logic [NE*DW-1:0] v;
        logic [NE*DW-1:0] v2;
        logic [AW-1:0]    b;
        int idle_busy;
        bit ok, poked;
        for (int pass = 0; pass < 2; pass++) begin
            clear_log();
            rand_vec(v);
            b = (pass == 0) ? 32'h200 : 32'hFFFF_FFFC;
            mem_ready = 1'b1;
            start_store(b, v, 1'b1);
            if (pass == 0) begin
                poked = 1'b0;
                for (int c = 0; c < 20; c++) begin
                    if (mem_we && mem_addr == b + AW'(3 * STR)) begin
                        rand_vec(v2);
                        base_addr = 32'h5000; r_vec = v2; store_req = 1'b1;
                        tick();
                        store_req = 1'b0; poked = 1'b1;
                        break;
                    end
                    tick();
                end
                n_checks++; if (!poked) begin n_fail++;
                    $display("FAIL ign_reach_idx3: got 0 expected 1"); end
            end
            wait_store_done(40, ok);
            mat_done = 1'b0;
            tick();
            idle_busy = 0;
            for (int c = 0; c < 5; c++) begin
                if (busy) idle_busy++;
                tick();
            end
            n_checks++; if (!ok || idle_busy !== 0 || done_cnt !== 1) begin n_fail++;
                $display("FAIL ign_no_restart: done=%b busy cycles %0d dones %0d expected 1 0 1",
                         ok, idle_busy, done_cnt); end
            n_checks++; if (wq_addr.size() !== NE) begin n_fail++;
                $display("FAIL ign_count[%0d]: got %0d expected %0d", pass, wq_addr.size(), NE); end
            for (int k = 0; k < NE; k++) begin
                n_checks++;
                if (wq_addr[k] !== b + AW'(k * STR) || wq_data[k] !== v[DW*k +: DW]) begin
                    n_fail++;
                    $display("FAIL ign_wrap_word[%0d.%0d]: got %h/%h expected %h/%h", pass, k,
                             wq_addr[k], wq_data[k], b + AW'(k * STR), v[DW*k +: DW]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [NE*DW-1:0] v;
        int nw;
        bit ok, reached;
        clear_log();
        rand_vec(v);
        mem_ready = 1'b1;
        start_store(32'h300, v, 1'b1);
        reached = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mem_we && mem_addr == 32'h30C) begin reached = 1'b1; break; end
            tick();
        end
        reset = 1'b1;
        tick();
        n_checks++; if (!reached || {mem_we, busy, stall, store_done} !== 4'b0) begin n_fail++;
            $display("FAIL rst_mid: reached=%b we/busy/stall/done got %b expected 1 0000",
                     reached, {mem_we, busy, stall, store_done}); end
        reset = 1'b0; mat_done = 1'b0;
        nw = wq_addr.size();
        for (int c = 0; c < 5; c++) tick();
        n_checks++; if (wq_addr.size() !== nw || done_cnt !== 0 || err_cnt !== 0) begin n_fail++;
            $display("FAIL rst_aftermath: writes %0d dones %0d errs %0d expected %0d 0 0",
                     wq_addr.size(), done_cnt, err_cnt, nw); end
        clear_log();
        rand_vec(v);
        start_store(32'h400, v, 1'b1);
        wait_store_done(40, ok);
        mat_done = 1'b0;
        tick();
        n_checks++; if (!ok || wq_addr.size() !== NE || done_cnt !== 1) begin n_fail++;
            $display("FAIL rst_fresh: done=%b writes %0d dones %0d expected 1 %0d 1",
                     ok, wq_addr.size(), done_cnt, NE); end
        for (int k = 0; k < NE; k++) begin
            n_checks++;
            if (wq_addr[k] !== 32'h400 + AW'(k * STR) || wq_data[k] !== v[DW*k +: DW]) begin
                n_fail++;
                $display("FAIL rst_fresh_word[%0d]: got %h/%h expected %h/%h", k,
                         wq_addr[k], wq_data[k], 32'h400 + AW'(k * STR), v[DW*k +: DW]);
            end
        end
    endtask

`ifdef MATSTORE_TIMEOUT_EN
    task automatic test_timeout;
        logic [NE*DW-1:0] v;
        int c;
        clear_log();
        rand_vec(v);
        mem_ready = 1'b1;
        start_store(32'h500, v, 1'b0);
        c = 1;
        while (c <= 4 * TO && !err) begin
            tick();
            c++;
        end
        n_checks++; if (c !== TO || busy !== 1'b1) begin n_fail++;
            $display("FAIL to_err_cycle: err at cycle %0d busy %b expected %0d 1", c, busy, TO); end
        tick();
        n_checks++; if ({busy, err} !== 2'b00) begin n_fail++;
            $display("FAIL to_after: busy/err got %b expected 00", {busy, err}); end
        tick(); tick();
        n_checks++; if (err_cnt !== 1 || wq_addr.size() !== 0 || done_cnt !== 0) begin n_fail++;
            $display("FAIL to_counts: errs %0d writes %0d dones %0d expected 1 0 0",
                     err_cnt, wq_addr.size(), done_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_late_done_snapshot();
        test_ignored_and_wrap();
        test_reset_mid();
`ifdef MATSTORE_TIMEOUT_EN
        test_timeout();
`else
        n_checks++; if (err_total !== 0) begin n_fail++;
            $display("FAIL err_tied_low: pulses %0d expected 0", err_total); end
`endif
        n_checks++; if (stall_bad !== 0) begin n_fail++;
            $display("FAIL stall_eq_busy: differing cycles %0d expected 0", stall_bad); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
